// File: rtl/cpu_pkg.sv
// Shared types for the 5-stage core: widths, ALU encodings,
// forward-select enum and the ID/EX bundle.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 3;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SLL  = 3'b011,
        ALU_SRAI = 3'b100,
        ALU_ADDI = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_MUL  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   rs1data;
        logic [XLEN-1:0]   rs2data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [CTRL_W-1:0] aluctrl;
        logic              alusrc;
        logic              regwrite;
        logic              memtoreg;
        logic              memread;
        logic              memwrite;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// fwd_sel: per-operand forward decision and operand mux.
// Ports: rs/rs_data (registered), exmem_*/memwb_* (live), op (selected).
// Build macro ID_EX_FWD_EN enables forwarding; otherwise op = rs_data.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rs_data,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_data,
    output logic [XLEN-1:0]   op
);

    fwd_sel_e sel;

`ifdef ID_EX_FWD_EN
    logic hit_ex;
    logic hit_mem;

    // x0 never forwards; the newest producer (EX/MEM) wins.
    assign hit_ex  = exmem_regwrite
                  && (exmem_rd != '0)
                  && (exmem_rd == rs);
    assign hit_mem = memwb_regwrite
                  && (memwb_rd != '0)
                  && (memwb_rd == rs)
                  && !hit_ex;

    always_comb begin
        sel = FWD_REG;
        unique case (1'b1)
            hit_ex:  sel = FWD_EXMEM;
            hit_mem: sel = FWD_MEMWB;
            default: sel = FWD_REG;
        endcase
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{rs, exmem_regwrite, exmem_rd,
                          exmem_result, memwb_regwrite,
                          memwb_rd, memwb_data};
    assign sel = FWD_REG;
`endif

    always_comb begin
        op = rs_data;
        unique case (sel)
            FWD_EXMEM: op = exmem_result;
            FWD_MEMWB: op = memwb_data;
            default:   op = rs_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand select (forwarding, ALUSrc).
// In: clk_i, rst_i (async low), stall_i, flush_i, id_*, exmem_*, memwb_*.
// Out: data1_o/data2_o/aluctrl_o to ALU, storedata_o, rd/rs1/rs2_o,
// valid_o and registered controls. Macro ID_EX_FWD_EN enables forwarding.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_rs1data_i,
    input  logic [XLEN-1:0]   id_rs2data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [CTRL_W-1:0] id_aluctrl_i,
    input  logic              id_alusrc_i,
    input  logic              id_regwrite_i,
    input  logic              id_memtoreg_i,
    input  logic              id_memread_i,
    input  logic              id_memwrite_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]   exmem_result_i,
    input  logic              memwb_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]   memwb_data_i,
    output logic [XLEN-1:0]   data1_o,
    output logic [XLEN-1:0]   data2_o,
    output logic [CTRL_W-1:0] aluctrl_o,
    output logic [XLEN-1:0]   storedata_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic              valid_o,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic              memread_o,
    output logic              memwrite_o
);

    id_ex_t d;
    id_ex_t q;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    // Invalid slots carry no side effects: all controls zeroed.
    always_comb begin
        d         = '0;
        d.valid   = id_valid_i;
        d.rs1data = id_rs1data_i;
        d.rs2data = id_rs2data_i;
        d.imm     = id_imm_i;
        d.rs1     = id_rs1_i;
        d.rs2     = id_rs2_i;
        d.rd      = id_rd_i;
        if (id_valid_i) begin
            d.aluctrl  = id_aluctrl_i;
            d.alusrc   = id_alusrc_i;
            d.regwrite = id_regwrite_i;
            d.memtoreg = id_memtoreg_i;
            d.memread  = id_memread_i;
            d.memwrite = id_memwrite_i;
        end
    end

    // Flush beats stall; bubble is an all-zero bundle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q <= '0;
        end else if (flush_i) begin
            q <= '0;
        end else if (!stall_i) begin
            q <= d;
        end
    end

    fwd_sel u_fwd1 (
        .rs             (q.rs1),
        .rs_data        (q.rs1data),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_rd       (exmem_rd_i),
        .exmem_result   (exmem_result_i),
        .memwb_regwrite (memwb_regwrite_i),
        .memwb_rd       (memwb_rd_i),
        .memwb_data     (memwb_data_i),
        .op             (op1)
    );

    fwd_sel u_fwd2 (
        .rs             (q.rs2),
        .rs_data        (q.rs2data),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_rd       (exmem_rd_i),
        .exmem_result   (exmem_result_i),
        .memwb_regwrite (memwb_regwrite_i),
        .memwb_rd       (memwb_rd_i),
        .memwb_data     (memwb_data_i),
        .op             (op2)
    );

    assign data1_o     = op1;
    assign data2_o     = q.alusrc ? q.imm : op2;
    // Stores need the forwarded rs2 even when the ALU takes the imm.
    assign storedata_o = op2;
    assign aluctrl_o   = q.aluctrl;
    assign rd_o        = q.rd;
    assign rs1_o       = q.rs1;
    assign rs2_o       = q.rs2;
    assign valid_o     = q.valid;
    assign regwrite_o  = q.regwrite;
    assign memtoreg_o  = q.memtoreg;
    assign memread_o   = q.memread;
    assign memwrite_o  = q.memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: spec-level model plus directed vectors.
// Works with or without ID_EX_FWD_EN defined.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_rs1data = '0;
    logic [31:0] id_rs2data = '0;
    logic [31:0] id_imm = '0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    logic [2:0]  id_aluctrl = '0;
    logic        id_alusrc = 1'b0;
    logic        id_regwrite = 1'b0;
    logic        id_memtoreg = 1'b0;
    logic        id_memread = 1'b0;
    logic        id_memwrite = 1'b0;
    logic        ex_rw = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_res = '0;
    logic        wb_rw = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    logic [31:0] data1, data2, storedata;
    logic [2:0]  aluctrl;
    logic [4:0]  rd, rs1, rs2;
    logic        valid, regwrite, memtoreg, memread, memwrite;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .stall_i          (stall),
        .flush_i          (flush),
        .id_valid_i       (id_valid),
        .id_rs1data_i     (id_rs1data),
        .id_rs2data_i     (id_rs2data),
        .id_imm_i         (id_imm),
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_rd_i          (id_rd),
        .id_aluctrl_i     (id_aluctrl),
        .id_alusrc_i      (id_alusrc),
        .id_regwrite_i    (id_regwrite),
        .id_memtoreg_i    (id_memtoreg),
        .id_memread_i     (id_memread),
        .id_memwrite_i    (id_memwrite),
        .exmem_regwrite_i (ex_rw),
        .exmem_rd_i       (ex_rd),
        .exmem_result_i   (ex_res),
        .memwb_regwrite_i (wb_rw),
        .memwb_rd_i       (wb_rd),
        .memwb_data_i     (wb_data),
        .data1_o          (data1),
        .data2_o          (data2),
        .aluctrl_o        (aluctrl),
        .storedata_o      (storedata),
        .rd_o             (rd),
        .rs1_o            (rs1),
        .rs2_o            (rs2),
        .valid_o          (valid),
        .regwrite_o       (regwrite),
        .memtoreg_o       (memtoreg),
        .memread_o        (memread),
        .memwrite_o       (memwrite)
    );

    // Model: what EX currently holds (one instruction slot).
    logic        m_valid = 0;
    logic [31:0] m_d1 = 0, m_d2 = 0, m_imm = 0;
    logic [4:0]  m_rs1 = 0, m_rs2 = 0, m_rd = 0;
    logic [2:0]  m_alu = 0;
    logic        m_src = 0, m_rw = 0, m_mtr = 0, m_mr = 0, m_mw = 0;

    task automatic model_bubble();
        m_valid <= 0; m_d1 <= 0; m_d2 <= 0; m_imm <= 0;
        m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_alu <= 0;
        m_src <= 0; m_rw <= 0; m_mtr <= 0; m_mr <= 0; m_mw <= 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            model_bubble();
        end else if (!stall) begin
            m_valid <= id_valid;
            m_d1 <= id_rs1data;
            m_d2 <= id_rs2data;
            m_imm <= id_imm;
            m_rs1 <= id_rs1;
            m_rs2 <= id_rs2;
            m_rd <= id_rd;
            m_alu <= id_valid ? id_aluctrl : 3'd0;
            m_src <= id_valid & id_alusrc;
            m_rw <= id_valid & id_regwrite;
            m_mtr <= id_valid & id_memtoreg;
            m_mr <= id_valid & id_memread;
            m_mw <= id_valid & id_memwrite;
        end
    end

    function automatic logic [31:0] fwd(logic [4:0] r, logic [31:0] v);
        if (FWD && r != 0 && ex_rw && ex_rd == r) return ex_res;
        if (FWD && r != 0 && wb_rw && wb_rd == r) return wb_data;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("data1", data1, fwd(m_rs1, m_d1));
            chk("data2", data2, m_src ? m_imm : fwd(m_rs2, m_d2));
            chk("store", storedata, fwd(m_rs2, m_d2));
            chk("alu", {29'd0, aluctrl}, {29'd0, m_alu});
            chk("rd", {27'd0, rd}, {27'd0, m_rd});
            chk("rs1", {27'd0, rs1}, {27'd0, m_rs1});
            chk("rs2", {27'd0, rs2}, {27'd0, m_rs2});
            chk("ctl", {27'd0, valid, regwrite, memtoreg, memread,
                        memwrite},
                {27'd0, m_valid, m_rw, m_mtr, m_mr, m_mw});
        end
    end

    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic no_fwd();
        ex_rw = 0; ex_rd = 0; ex_res = 0;
        wb_rw = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic load(logic [4:0] r1, logic [31:0] v1,
                        logic [4:0] r2, logic [31:0] v2,
                        logic [31:0] im, logic [4:0] d,
                        logic [2:0] a, logic s, logic [3:0] c);
        id_valid = 1;
        id_rs1 = r1; id_rs1data = v1;
        id_rs2 = r2; id_rs2data = v2;
        id_imm = im; id_rd = d; id_aluctrl = a; id_alusrc = s;
        {id_regwrite, id_memtoreg, id_memread, id_memwrite} = c;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data1", data1, 32'd0);
        #1 rst_n = 1;

        // Plain load, no forwarding.
        no_fwd();
        load(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd4, 3'b010, 0, 4'b1000);
        next();
        chk("plain_d1", data1, 32'd5);
        chk("plain_d2", data2, 32'd7);
        chk("plain_alu", {29'd0, aluctrl}, 32'd2);
        chk("plain_v", {31'd0, valid}, 32'd1);

        // Double hazard on rs1.
        #1;
        load(5'd3, 32'h33, 5'd2, 32'd7, 32'd0, 5'd4, 3'b110, 0, 4'b1000);
        ex_rw = 1; ex_rd = 3; ex_res = 32'h100;
        wb_rw = 1; wb_rd = 3; wb_data = 32'h200;
        next();
        chk("dbl_ex", data1, FWD ? 32'h100 : 32'h33);
        #1 stall = 1; ex_rw = 0;
        next();
        chk("dbl_wb", data1, FWD ? 32'h200 : 32'h33);
        #1 stall = 0; no_fwd();

        // x0 never forwards; imm select vs store data.
        load(5'd0, 32'h11, 5'd6, 32'h66, 32'hFFFF_FFFC, 5'd7,
             3'b101, 1, 4'b0001);
        ex_rw = 1; ex_rd = 0; ex_res = 32'hDEAD;
        wb_rw = 1; wb_rd = 6; wb_data = 32'd9;
        next();
        chk("x0_d1", data1, 32'h11);
        chk("imm_d2", data2, 32'hFFFF_FFFC);
        chk("st_fwd", storedata, FWD ? 32'd9 : 32'h66);

        // Stall 3 cycles with changing ID inputs.
        #1 stall = 1; no_fwd();
        for (int i = 0; i < 3; i++) begin
            load(5'(10 + i), 32'(i), 5'd8, 32'd1, 32'd2, 5'(20 + i),
                 3'b011, 0, 4'b1100);
            next();
            chk("stall_d1", data1, 32'h11);
            chk("stall_rd", {27'd0, rd}, 32'd7);
            chk("stall_mw", {31'd0, memwrite}, 32'd1);
            #1;
        end

        // Flush beats stall.
        flush = 1;
        next();
        chk("fl_v", {31'd0, valid}, 32'd0);
        chk("fl_rw", {31'd0, regwrite}, 32'd0);
        chk("fl_mw", {31'd0, memwrite}, 32'd0);
        #1 flush = 0; stall = 0;

        // Invalid slot drops controls.
        load(5'd1, 32'd1, 5'd2, 32'd2, 32'd3, 5'd5, 3'b111, 1, 4'b1111);
        id_valid = 0;
        next();
        chk("inv_rw", {31'd0, regwrite}, 32'd0);
        chk("inv_d2", data2, 32'd2);

        // Asynchronous reset mid-cycle with a loaded slot.
        #1;
        load(5'd9, 32'h99, 5'd2, 32'd2, 32'd3, 5'd5, 3'b001, 0, 4'b1010);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("arst_d1", data1, 32'd0);
        chk("arst_v", {31'd0, valid}, 32'd0);
        chk("arst_rd", {27'd0, rd}, 32'd0);
        stall = 1;
        next();
        #1 rst_n = 1;
        next();
        chk("post_rst_v", {31'd0, valid}, 32'd0);
        #1 stall = 0;

        // Directed-random mix, checked by the model every cycle.
        for (int i = 0; i < 60; i++) begin
            load(5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), $urandom, $urandom,
                 5'($urandom), 3'($urandom), 1'($urandom),
                 4'($urandom));
            id_valid = ($urandom_range(0, 5) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            ex_rw = 1'($urandom); ex_rd = 5'($urandom_range(0, 7));
            ex_res = $urandom;
            wb_rw = 1'($urandom); wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            next();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX operand selection for the 5-stage core.
- Captures decoded operands, immediate, register addresses and control bits at the end of ID.
- Resolves EX/MEM and MEM/WB forwarding and the ALUSrc immediate select.
- Drives the ALU's data1_i, data2_i and ALUCtrl_i directly; passes memory and writeback controls on to the EX/MEM register.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.
- CTRL_W, 3, ALU control width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold all registered fields.
- flush_i  in  1  load a bubble.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1data_i  in  XLEN  register-file read port 1.
- id_rs2data_i  in  XLEN  register-file read port 2.
- id_imm_i  in  XLEN  sign-extended immediate.
- id_rs1_i  in  REG_AW  source register 1 address.
- id_rs2_i  in  REG_AW  source register 2 address.
- id_rd_i  in  REG_AW  destination register address.
- id_aluctrl_i  in  CTRL_W  ALU operation select.
- id_alusrc_i  in  1  1 = use immediate as operand 2.
- id_regwrite_i  in  1  writeback enable.
- id_memtoreg_i  in  1  writeback from memory.
- id_memread_i  in  1  load.
- id_memwrite_i  in  1  store.
- exmem_regwrite_i  in  1  EX/MEM stage writes a register.
- exmem_rd_i  in  REG_AW  EX/MEM destination address.
- exmem_result_i  in  XLEN  EX/MEM ALU result.
- memwb_regwrite_i  in  1  MEM/WB stage writes a register.
- memwb_rd_i  in  REG_AW  MEM/WB destination address.
- memwb_data_i  in  XLEN  MEM/WB writeback value.
- data1_o  out  XLEN  ALU operand 1.
- data2_o  out  XLEN  ALU operand 2.
- aluctrl_o  out  CTRL_W  to ALU.
- storedata_o  out  XLEN  forwarded rs2 value for stores.
- rd_o  out  REG_AW  registered rd.
- rs1_o  out  REG_AW  registered rs1, to hazard unit.
- rs2_o  out  REG_AW  registered rs2, to hazard unit.
- valid_o  out  1  EX holds a real instruction.
- regwrite_o, memtoreg_o, memread_o, memwrite_o  out  1 each  registered controls.

Behaviour:
- Reset (rst_i=0, async): every registered field, and therefore every register-sourced output, clears to 0; valid_o=0.
- data1_o, data2_o and storedata_o are combinational from zeroed fields and live forwarding inputs; a forwarding match against rs=0 never fires.
- Register update at rising clk_i, one-cycle latency ID to EX. Priority:
  - flush_i=1: load bubble. valid, regwrite, memtoreg, memread, memwrite, aluctrl, rd, rs1, rs2 all cleared to 0. Data fields are don't-care but cleared to 0 for determinism. Flush wins over stall.
  - else stall_i=1: all fields hold.
  - else: all fields load from id_* inputs; valid <= id_valid_i.
- An invalid instruction (id_valid_i=0) loads with all controls forced to 0.
- Forwarding, computed per operand X in {1,2} from registered rsX:
  - fwd_ex = exmem_regwrite_i && exmem_rd_i!=0 && exmem_rd_i==rsX.
  - fwd_mem = memwb_regwrite_i && memwb_rd_i!=0 && memwb_rd_i==rsX && !fwd_ex.
  - Selected value opX = fwd_ex ? exmem_result_i : fwd_mem ? memwb_data_i : registered rsXdata.
  - EX/MEM has priority over MEM/WB (newest producer wins).
- data1_o = op1.
- data2_o = alusrc ? registered imm : op2.
- storedata_o = op2 always, so stores forward their data even when alusrc=1.
- Forwarding is purely combinational from current-cycle inputs: no extra latency and no storage of forwarded values.
- Register x0: rs=0 never forwards; the registered data is used (the register file guarantees it is 0).
- Stall held across N cycles: forwarding re-evaluates every cycle against the new EX/MEM and MEM/WB contents.
- Reset mid-stall: reset wins; a bubble is present after release.
- No arithmetic performed; widths pass through unchanged.

Optional Feature:
- ID_EX_FWD_EN.
- Defined: forwarding logic as above.
- Undefined:
  - opX = registered rsXdata; exmem_* and memwb_* inputs are ignored (ports retained).
  - The hazard unit must stall for every RAW hazard.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN, REG_AW, CTRL_W.
  - ALU control encodings: AND=000, XOR=001, ADD=010, SLL=011, SRAI=100, ADDI=101, SUB=110, MUL=111.
  - Forward-select enum: FWD_REG, FWD_EXMEM, FWD_MEMWB.
- One natural sub-module: fwd_sel, the per-operand forward decision plus mux, instantiated twice.

Test Plan:
- Reset: assert rst_i=0 mid-cycle with fields loaded -> all outputs 0 immediately (async); valid_o=0.
- Plain load: rs1data=5, rs2data=7, aluctrl=010, alusrc=0, no matches -> next cycle data1_o=5, data2_o=7, aluctrl_o=010.
- Double hazard: rs1=3, exmem_rd=3 regwrite=1 result=0x100, memwb_rd=3 regwrite=1 data=0x200 -> data1_o=0x100.
- x0 and immediate: rs1=0 with exmem_rd=0 regwrite=1 -> no forward, data1_o=registered value. alusrc=1, imm=-4, rs2 forwarded 9 -> data2_o=0xFFFFFFFC, storedata_o=9.
- Stall vs flush: stall_i=1 for 3 cycles with new id_* inputs -> outputs unchanged. stall_i=1 and flush_i=1 together -> bubble: valid_o=0, regwrite_o=0, memwrite_o=0.
- ID_EX_FWD_EN undefined: build without macro, exmem match on rs1 -> data1_o=registered rs1data.
